// File: rtl/ct_l2cache_pkg.sv
// Shared definitions for the L2 data-array access controller: FSM states, line geometry, defaults.
package ct_l2cache_pkg;

  localparam int L2C_BANK_W = 128;
  localparam int L2C_BANKS  = 4;
  localparam int L2C_LINE_W = L2C_BANKS * L2C_BANK_W;
  localparam int L2C_IDX_W  = 13;
  localparam int L2C_LAT_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } l2c_state_e;

endpackage

// File: rtl/ct_l2cache_lat_cnt.sv
// RAM read-latency counter: loaded at the ACCESS cycle, decremented through WAIT.
// zero_next flags the WAIT cycle whose decrement brings the count to zero.
module ct_l2cache_lat_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_next
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign zero_next = dec && (cnt_reg <= W'(1));

endmodule

// File: rtl/ct_l2cache_data_acc_ctrl.sv
// L2 data-array access controller: one line request in, banked SRAM pin timing out, read line or write ack back.
// Optional build macro L2C_DATA_PERF_CNT_EN adds perf_clr / perf_rd_cnt / perf_wr_cnt.
module ct_l2cache_data_acc_ctrl
  import ct_l2cache_pkg::*;
#(
  parameter int IDX_W = L2C_IDX_W,
  parameter int BANKS = L2C_BANKS,
  parameter int LAT_W = L2C_LAT_W
) (
  input  logic                        forever_cpuclk,
  input  logic                        cpurst_b,
  input  logic                        cfg_data_setup,
  input  logic [LAT_W-1:0]            cfg_data_latency,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_wr,
  input  logic [BANKS-1:0]            req_bank_en,
  input  logic [IDX_W-1:0]            req_index,
  input  logic [BANKS*L2C_BANK_W-1:0] req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_wr,
  output logic [BANKS*L2C_BANK_W-1:0] rsp_rdata,
  output logic [BANKS-1:0]            l2c_data_ram_cen,
  output logic [BANKS-1:0]            l2c_data_wen,
  output logic [IDX_W-1:0]            l2c_data_index0,
  output logic [IDX_W-1:0]            l2c_data_index1,
  output logic [IDX_W-1:0]            l2c_data_index2,
  output logic [IDX_W-1:0]            l2c_data_index3,
  output logic [BANKS*L2C_BANK_W-1:0] l2c_data_din,
  input  logic [BANKS*L2C_BANK_W-1:0] l2c_data_dout
`ifdef L2C_DATA_PERF_CNT_EN
  ,
  input  logic                        perf_clr,
  output logic [31:0]                 perf_rd_cnt,
  output logic [31:0]                 perf_wr_cnt
`endif
);

  localparam int LINE_W = BANKS * L2C_BANK_W;

  l2c_state_e        state_reg, state_next;
  logic              wr_reg, wr_next;
  logic [BANKS-1:0]  bank_en_reg, bank_en_next;
  logic [LAT_W-1:0]  lat_reg, lat_next;
  logic [BANKS-1:0]  cen_reg, cen_next;
  logic [BANKS-1:0]  wen_reg, wen_next;
  logic [IDX_W-1:0]  index_reg, index_next;
  logic [LINE_W-1:0] din_reg, din_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic              rsp_wr_reg, rsp_wr_next;
  logic [LINE_W-1:0] rdata_reg, rdata_next;
  logic [LINE_W-1:0] rd_mask;
  logic              cnt_load, cnt_dec, cnt_zero_next;

  // Disabled banks read back as zero regardless of what the RAM drives.
  for (genvar gi = 0; gi < BANKS; gi++) begin : g_rd_mask
    assign rd_mask[gi*L2C_BANK_W +: L2C_BANK_W] = {L2C_BANK_W{bank_en_reg[gi]}};
  end

  ct_l2cache_lat_cnt #(
    .W(LAT_W)
  ) u_lat_cnt (
    .clk       (forever_cpuclk),
    .rst_n     (cpurst_b),
    .load      (cnt_load),
    .load_val  (lat_reg),
    .dec       (cnt_dec),
    .zero_next (cnt_zero_next)
  );

  always_comb begin
    state_next     = state_reg;
    wr_next        = wr_reg;
    bank_en_next   = bank_en_reg;
    lat_next       = lat_reg;
    cen_next       = '1;
    wen_next       = wen_reg;
    index_next     = index_reg;
    din_next       = din_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_wr_next    = rsp_wr_reg;
    rdata_next     = rdata_reg;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          wr_next      = req_wr;
          bank_en_next = req_bank_en;
          lat_next     = (cfg_data_latency == '0) ? LAT_W'(1) : cfg_data_latency;
          wen_next     = ~({BANKS{req_wr}} & req_bank_en);
          index_next   = req_index;
          din_next     = req_wdata;
          if (req_bank_en == '0) begin
            state_next     = ST_RESP;
            rsp_valid_next = 1'b1;
            rsp_wr_next    = req_wr;
            rdata_next     = '0;
          end else if (cfg_data_setup) begin
            state_next = ST_SETUP;
          end else begin
            state_next = ST_ACCESS;
            cen_next   = ~req_bank_en;
          end
        end
      end
      ST_SETUP: begin
        state_next = ST_ACCESS;
        cen_next   = ~bank_en_reg;
      end
      ST_ACCESS: begin
        state_next = ST_WAIT;
        cnt_load   = 1'b1;
      end
      ST_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_zero_next) begin
          state_next     = ST_RESP;
          rsp_valid_next = 1'b1;
          rsp_wr_next    = wr_reg;
          rdata_next     = wr_reg ? '0 : (l2c_data_dout & rd_mask);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next     = ST_IDLE;
          rsp_valid_next = 1'b0;
          wen_next       = '1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_reg     <= ST_IDLE;
      wr_reg        <= 1'b0;
      bank_en_reg   <= '0;
      lat_reg       <= LAT_W'(1);
      cen_reg       <= '1;
      wen_reg       <= '1;
      index_reg     <= '0;
      din_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_wr_reg    <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      wr_reg        <= wr_next;
      bank_en_reg   <= bank_en_next;
      lat_reg       <= lat_next;
      cen_reg       <= cen_next;
      wen_reg       <= wen_next;
      index_reg     <= index_next;
      din_reg       <= din_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_wr_reg    <= rsp_wr_next;
      rdata_reg     <= rdata_next;
    end
  end

  assign req_ready        = (state_reg == ST_IDLE);
  assign rsp_valid        = rsp_valid_reg;
  assign rsp_wr           = rsp_wr_reg;
  assign rsp_rdata        = rdata_reg;
  assign l2c_data_ram_cen = cen_reg;
  assign l2c_data_wen     = wen_reg;
  assign l2c_data_index0  = index_reg;
  assign l2c_data_index1  = index_reg;
  assign l2c_data_index2  = index_reg;
  assign l2c_data_index3  = index_reg;
  assign l2c_data_din     = din_reg;

`ifdef L2C_DATA_PERF_CNT_EN
  logic [31:0] perf_rd_cnt_reg, perf_wr_cnt_reg;

  // One count per ACCESS cycle, i.e. per real RAM access; bank_en=0 no-ops never reach ACCESS.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      perf_rd_cnt_reg <= '0;
      perf_wr_cnt_reg <= '0;
    end else if (perf_clr) begin
      perf_rd_cnt_reg <= '0;
      perf_wr_cnt_reg <= '0;
    end else if (state_reg == ST_ACCESS) begin
      if (wr_reg) begin
        if (perf_wr_cnt_reg != '1) perf_wr_cnt_reg <= perf_wr_cnt_reg + 32'd1;
      end else begin
        if (perf_rd_cnt_reg != '1) perf_rd_cnt_reg <= perf_rd_cnt_reg + 32'd1;
      end
    end
  end

  assign perf_rd_cnt = perf_rd_cnt_reg;
  assign perf_wr_cnt = perf_wr_cnt_reg;
`endif

endmodule

// File: tb/tb_ct_l2cache_data_acc_ctrl.sv
// Bench for ct_l2cache_data_acc_ctrl: transaction-level model of the request/RAM/response timing,
// checked every cycle, plus literal expectations for the directed cases.
module tb_ct_l2cache_data_acc_ctrl;

  localparam int LW = 512;
  localparam int BW = 128;
  localparam int IW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_setup = 1'b0;
  logic [1:0]    cfg_lat = 2'd0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wr = 1'b0;
  logic [3:0]    req_be = 4'h0;
  logic [IW-1:0] req_idx = '0;
  logic [LW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_wr;
  logic [LW-1:0] rsp_rdata;
  logic [3:0]    cen, wen;
  logic [IW-1:0] idx0, idx1, idx2, idx3;
  logic [LW-1:0] din;
  logic [LW-1:0] dout = '0;
`ifdef L2C_DATA_PERF_CNT_EN
  logic          perf_clr = 1'b0;
  logic [31:0]   perf_rd, perf_wr;
`endif

  always #5 clk = ~clk;

  ct_l2cache_data_acc_ctrl dut (
    .forever_cpuclk   (clk),
    .cpurst_b         (rst_n),
    .cfg_data_setup   (cfg_setup),
    .cfg_data_latency (cfg_lat),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_wr           (req_wr),
    .req_bank_en      (req_be),
    .req_index        (req_idx),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_wr           (rsp_wr),
    .rsp_rdata        (rsp_rdata),
    .l2c_data_ram_cen (cen),
    .l2c_data_wen     (wen),
    .l2c_data_index0  (idx0),
    .l2c_data_index1  (idx1),
    .l2c_data_index2  (idx2),
    .l2c_data_index3  (idx3),
    .l2c_data_din     (din),
    .l2c_data_dout    (dout)
`ifdef L2C_DATA_PERF_CNT_EN
    ,
    .perf_clr         (perf_clr),
    .perf_rd_cnt      (perf_rd),
    .perf_wr_cnt      (perf_wr)
`endif
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int txn_no = 0;

  // Transaction model: k counts cycles since the accept edge (cycle 1 is the first after it).
  bit            m_busy = 1'b0;
  int            m_k = 0;
  int            m_resp_k = 0;
  int            m_s = 0;
  int            m_l = 1;
  logic          m_wr = 1'b0;
  logic [3:0]    m_be = 4'h0;
  logic [IW-1:0] m_idx = '0;
  logic [LW-1:0] m_din = '0;
  logic [LW-1:0] m_pat = '0;

  // Observations of the transaction in flight, for the literal checks.
  int            obs_rsp_k = 0;
  int            obs_cen_k = 0;
  int            obs_cen_pulses = 0;
  int            obs_valid_cycles = 0;
  logic [3:0]    obs_cen = 4'hF;
  logic [LW-1:0] obs_rdata = '0;
  logic          obs_rsp_wr = 1'b0;

  function automatic logic [LW-1:0] line_mask(input logic [3:0] be);
    logic [LW-1:0] r;
    for (int b = 0; b < 4; b++) r[b*BW +: BW] = {BW{be[b]}};
    return r;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_k    = 0;
      m_idx  = '0;
      m_din  = '0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy   = 1'b1;
        m_k      = 1;
        m_wr     = req_wr;
        m_be     = req_be;
        m_idx    = req_idx;
        m_din    = req_wdata;
        m_pat    = dout;
        m_s      = int'(cfg_setup);
        m_l      = (cfg_lat == 2'd0) ? 1 : int'(cfg_lat);
        m_resp_k = (req_be == 4'h0) ? 1 : 2 + m_s + m_l;
      end
    end else if (m_k >= m_resp_k && rsp_ready) begin
      m_busy = 1'b0;
    end else begin
      m_k++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic          e_valid;
      logic [3:0]    e_cen, e_wen;
      logic [LW-1:0] e_rdata;
      if (m_busy && m_k == 1) begin
        obs_rsp_k = 0; obs_cen_k = 0; obs_cen_pulses = 0; obs_valid_cycles = 0;
        obs_cen = 4'hF; obs_rdata = '0; obs_rsp_wr = 1'b0;
      end
      e_valid = m_busy && (m_k >= m_resp_k);
      e_cen   = (m_busy && m_be != 4'h0 && m_k == 1 + m_s) ? ~m_be : 4'hF;
      e_wen   = m_busy ? ~({4{m_wr}} & m_be) : 4'hF;
      e_rdata = m_wr ? '0 : (m_pat & line_mask(m_be));
      chk("req_ready", LW'(req_ready), LW'(!m_busy));
      chk("rsp_valid", LW'(rsp_valid), LW'(e_valid));
      chk("cen", LW'(cen), LW'(e_cen));
      chk("wen", LW'(wen), LW'(e_wen));
      chk("index0", LW'(idx0), LW'(m_idx));
      chk("index1", LW'(idx1), LW'(m_idx));
      chk("index2", LW'(idx2), LW'(m_idx));
      chk("index3", LW'(idx3), LW'(m_idx));
      chk("din", din, m_din);
      if (e_valid) begin
        chk("rsp_wr", LW'(rsp_wr), LW'(m_wr));
        chk("rsp_rdata", rsp_rdata, e_rdata);
      end
      if (m_busy) begin
        if (cen != 4'hF) begin
          obs_cen_pulses++;
          obs_cen_k = m_k;
          obs_cen   = cen;
        end
        if (rsp_valid) begin
          obs_valid_cycles++;
          if (obs_rsp_k == 0) begin
            obs_rsp_k  = m_k;
            obs_rdata  = rsp_rdata;
            obs_rsp_wr = rsp_wr;
          end
        end
      end
    end
  end

  // rsp_delay < 0: random rsp_ready; otherwise ready stays low for rsp_delay valid cycles.
  task automatic do_req(input bit wr, input logic [3:0] be, input logic [IW-1:0] idx, input bit s,
                        input logic [1:0] lat, input logic [LW-1:0] pat, input logic [LW-1:0] wd,
                        input int rsp_delay, input bit noise);
    int n;
    int vcnt;
    req_valid = 1'b1; req_wr = wr; req_be = be; req_idx = idx; req_wdata = wd;
    cfg_setup = s; cfg_lat = lat; dout = pat;
    n = 0;
    do begin
      @(posedge clk); #2; n++;
    end while (!m_busy && n < 20);
    if (!m_busy) begin
      total++; bad++;
      $display("FAIL accept_timeout act=0 exp=1 t=%0t", $time);
      req_valid = 1'b0;
      return;
    end
    vcnt = 0;
    n = 0;
    while (m_busy && n < 100) begin
      req_valid = noise ? 1'($urandom % 2) : 1'b0;
      if (noise) begin
        req_wr = 1'($urandom); req_be = 4'($urandom); req_idx = IW'($urandom);
        req_wdata = rand_line();
      end
      cfg_setup = 1'($urandom);
      cfg_lat   = 2'($urandom);
      if (m_k >= m_resp_k) vcnt++;
      rsp_ready = (rsp_delay < 0) ? 1'($urandom % 2) : (vcnt > rsp_delay);
      @(posedge clk); #2; n++;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    if (m_busy) begin
      total++; bad++;
      $display("FAIL rsp_timeout act=busy exp=idle t=%0t", $time);
    end
    dout = rand_line();
    txn_no++;
    $display("txn %0d wr=%0d be=%h idx=%h setup=%0d lat=%0d rsp_cycle=%0d valid_cycles=%0d",
             txn_no, wr, be, idx, s, lat, obs_rsp_k, obs_valid_cycles);
  endtask

  logic [LW-1:0] pat1, pat2, exp2, wd3;

  initial begin
    pat1 = {4{128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF}};
    pat2 = {128'h3333_3333_3333_3333_3333_3333_3333_3333, 128'h2222_2222_2222_2222_2222_2222_2222_2222,
            128'h1111_1111_1111_1111_1111_1111_1111_1111, 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F};
    exp2 = {128'h0, 128'h2222_2222_2222_2222_2222_2222_2222_2222,
            128'h0, 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F};
    wd3  = {64{8'hA5}};

    @(posedge clk); #2;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;

    // Read, no setup, lat=1.
    do_req(1'b0, 4'hF, 13'h1A5, 1'b0, 2'd1, pat1, rand_line(), 0, 1'b0);
    chk("t1_rsp_cycle", LW'(obs_rsp_k), LW'(3));
    chk("t1_cen_cycle", LW'(obs_cen_k), LW'(1));
    chk("t1_cen_pulses", LW'(obs_cen_pulses), LW'(1));
    chk("t1_rdata", obs_rdata, pat1);

    // Read with setup, lat=3, banks 0 and 2.
    do_req(1'b0, 4'b0101, 13'h0777, 1'b1, 2'd3, pat2, rand_line(), 0, 1'b0);
    chk("t2_rsp_cycle", LW'(obs_rsp_k), LW'(6));
    chk("t2_cen_cycle", LW'(obs_cen_k), LW'(2));
    chk("t2_cen_val", LW'(obs_cen), LW'(4'b1010));
    chk("t2_rdata", obs_rdata, exp2);

    // Write, all banks, lat=2.
    do_req(1'b1, 4'hF, 13'h1FFF, 1'b0, 2'd2, rand_line(), wd3, 0, 1'b0);
    chk("t3_rsp_wr", LW'(obs_rsp_wr), LW'(1));
    chk("t3_rdata", obs_rdata, '0);
    chk("t3_cen_pulses", LW'(obs_cen_pulses), LW'(1));
    chk("t3_rsp_cycle", LW'(obs_rsp_k), LW'(4));

    // Response back-pressure with competing requests; lat=0 behaves as 1.
    do_req(1'b0, 4'b0011, 13'h0042, 1'b0, 2'd0, pat1, rand_line(), 5, 1'b1);
    chk("t4_valid_cycles", LW'(obs_valid_cycles), LW'(6));
    chk("t4_rsp_cycle", LW'(obs_rsp_k), LW'(3));

    // Reset asserted during WAIT.
    req_valid = 1'b1; req_wr = 1'b0; req_be = 4'hF; req_idx = 13'h0123;
    cfg_setup = 1'b0; cfg_lat = 2'd3; dout = pat2;
    @(posedge clk); #2;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
    rst_n = 1'b0;
    #1;
    chk("t5_rst_cen", LW'(cen), LW'(4'hF));
    chk("t5_rst_wen", LW'(wen), LW'(4'hF));
    chk("t5_rst_rsp_valid", LW'(rsp_valid), LW'(0));
    chk("t5_rst_req_ready", LW'(req_ready), LW'(1));
    chk("t5_rst_index", LW'(idx0), LW'(0));
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #2;
    do_req(1'b0, 4'hF, 13'h0ABC, 1'b0, 2'd2, pat1, rand_line(), 1, 1'b0);
    chk("t5_after_rst_rdata", obs_rdata, pat1);
    chk("t5_after_rst_rsp_cycle", LW'(obs_rsp_k), LW'(4));

    // No-op request.
    do_req(1'b0, 4'h0, 13'h0555, 1'b1, 2'd3, pat1, rand_line(), 0, 1'b0);
    chk("t6_rsp_cycle", LW'(obs_rsp_k), LW'(1));
    chk("t6_cen_pulses", LW'(obs_cen_pulses), LW'(0));
    chk("t6_rdata", obs_rdata, '0);

`ifdef L2C_DATA_PERF_CNT_EN
    perf_clr = 1'b1;
    @(posedge clk); #2;
    perf_clr = 1'b0;
    chk("perf_clr_rd", LW'(perf_rd), LW'(0));
    chk("perf_clr_wr", LW'(perf_wr), LW'(0));
    for (int i = 0; i < 5; i++)
      do_req(i >= 3, 4'($urandom_range(1, 15)), IW'($urandom), 1'($urandom), 2'($urandom),
             rand_line(), rand_line(), -1, 1'b0);
    do_req(1'b0, 4'h0, 13'h0001, 1'b0, 2'd1, rand_line(), rand_line(), 0, 1'b0);
    chk("perf_rd_cnt", LW'(perf_rd), LW'(3));
    chk("perf_wr_cnt", LW'(perf_wr), LW'(2));
`endif

    for (int i = 0; i < 40; i++) begin
      logic [3:0] be;
      be = ($urandom % 5 == 0) ? 4'h0 : 4'($urandom);
      do_req(1'($urandom), be, IW'($urandom), 1'($urandom), 2'($urandom), rand_line(), rand_line(),
             ($urandom % 3 == 0) ? -1 : int'($urandom % 4), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
